data_ram_ws: RTL and testbench
==============================

Name: data_ram_ws

Overview:
Parametrised, multi-cycle successor of the MEM-stage data RAM. It has configurable data width, depth and wait states, and registered read data. A single-outstanding request protocol raises a stall toward the pipeline control unit, and out-of-range accesses are flagged. It sits between the MEM stage and `ctrl`, replacing the zero-latency data RAM when modelling slow memory.

Parameters:
DATA_W, 32, data width in bits; multiple of 8; BYTES = DATA_W/8 lanes.
ADDR_W, 17, word-index width; depth = 2**ADDR_W words.
WAIT_CYCLES, 2, extra wait cycles per access, 0..15.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous reset, active-high (`RstEnable).
ce  in  1  request valid; held high by MEM stage until ack_o.
we  in  1  1 = write, 0 = read.
addr  in  32  byte address; word index = addr[ADDR_W+1:2] (log2(BYTES) low bits when DATA_W≠32).
sel  in  BYTES  byte-lane enables; bit i writes data_i[8i+7:8i].
data_i  in  DATA_W  write data.
data_o  out  DATA_W  read data, registered; valid only while ack_o=1.
ack_o  out  1  one-cycle completion pulse, registered.
err_o  out  1  out-of-range flag, valid with ack_o.
stall_o  out  1  stall request to ctrl; combinational = ce & ~ack_o.

Behaviour:
- Reset: state=IDLE, cnt=0, data_o=`ZeroWord, ack_o=0, err_o=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, ACK.
- IDLE: if ce=1, latch we/addr/sel/data_i and compute range error.
  - WAIT_CYCLES>0: go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go to ACK.
- WAIT: cnt decrements each cycle. At cnt=0, go to ACK on the next edge.
- Write commit: on the edge that enters ACK, provided no range error. Only lanes with latched sel=1 are written.
- Read: data_o is loaded on the edge that enters ACK from the latched address.
- ACK: ack_o=1 for exactly one cycle, then unconditionally back to IDLE.
  - A new request is only accepted in IDLE.
  - Throughput: one access per WAIT_CYCLES+2 cycles.
- Latency: with the request accepted in cycle T, ack_o is high in cycle T+1+WAIT_CYCLES.
- Write acks drive data_o=`ZeroWord.
- Range error: addr bits above the word index (and below 32) are nonzero. Then err_o=1 with ack_o, no write, data_o=`ZeroWord.
- Request fields (we/addr/sel/data_i) changing after acceptance are ignored.
- ce dropping mid-access does not abort the access; it still completes and acks.
- sel=0 write: acks normally, memory unchanged.
- Reset mid-access: return to IDLE on that edge. An uncommitted write is discarded; memory is unaffected.
- Outside ACK: data_o=`ZeroWord, err_o=0.
- stall_o=1 in every cycle where ce=1 and ack_o=0, including the IDLE acceptance cycle.

Decomposition:
- Shared defines.v additions:
  - `DramIdle/`DramWait/`DramAck state encodings (2 bits).
  - `DramCntBus.
  - Reuse existing `RstEnable, `Enable, `Disable, `ZeroWord.
- Sub-module dram_byte_lane: 8-bit × 2**ADDR_W array with lane write enable and registered read. Instantiated BYTES times via generate.
- FSM, counter and range check live in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with ce=0 -> ack_o=0, err_o=0, data_o=0, stall_o=0.
- Full write then read, WAIT_CYCLES=2:
  - write 0xDEADBEEF to 0x100, sel=4'hF -> ack_o in cycle T+3, stall_o=1 in T..T+2.
  - read 0x100 -> data_o=0xDEADBEEF with ack_o.
- Byte lanes: write 0x11223344 sel=4'b0101 over 0xDEADBEEF at 0x100 -> read returns 0xDE22BE44.
- Range error, ADDR_W=17: write to 0x0008_0000 -> err_o=1 with ack_o; a following read of 0x0 still returns the prior value; read of 0x0008_0000 gives err_o=1, data_o=0.
- Reset mid-write: write 0x55 to 0x200 with WAIT_CYCLES=3, rst pulsed in T+2 -> no ack; read 0x200 returns the old value.
- WAIT_CYCLES=0 back-to-back reads with ce held high:
  - ack_o every 2nd cycle.
  - stall_o low only in ack cycles.

Source files
------------

// File: rtl/data_ram_ws_pkg.sv
// Shared types and helpers for the multi-cycle data RAM with wait states.
// Holds the FSM state encoding, the wait counter type and the range check.
package data_ram_ws_pkg;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'b00,
        DRAM_WAIT = 2'b01,
        DRAM_ACK  = 2'b10
    } dram_state_t;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] dram_cnt_t;

    // True when any address bit at or above top_lsb is set, i.e. beyond the array.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned top_lsb);
        if (top_lsb >= 32) begin
            return 1'b0;
        end
        return (addr >> top_lsb) != 32'h0;
    endfunction

endpackage

// File: rtl/data_ram_ws_byte_lane.sv
// One 8-bit lane of the data RAM: lane-enabled write and a registered read
// whose output is zero in every cycle that does not carry read data.
module data_ram_ws_byte_lane #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_rdata;

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a huge register file, and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_ws.sv
// Multi-cycle data RAM for the MEM stage: single outstanding request, WAIT_CYCLES
// extra cycles per access, one-cycle ack, range error flag and stall to ctrl.
module data_ram_ws
    import data_ram_ws_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o
);

    localparam int BYTES   = DATA_W / 8;
    localparam int OFF_W   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int TOP_LSB = ADDR_W + OFF_W;
    localparam dram_cnt_t CNT_INIT =
        (WAIT_CYCLES > 0) ? dram_cnt_t'(WAIT_CYCLES - 1) : '0;

    dram_state_t       r_state;
    dram_state_t       w_next;
    dram_cnt_t         r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [BYTES-1:0]  r_sel;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;

    logic              w_idle;
    logic              w_accept;
    logic              w_cur_we;
    logic [31:0]       w_cur_addr;
    logic [BYTES-1:0]  w_cur_sel;
    logic [DATA_W-1:0] w_cur_wdata;
    logic              w_cur_err;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_enter_ack;
    logic              w_rd_en;
    logic [BYTES-1:0]  w_wr_lane;

    assign w_idle   = (r_state == DRAM_IDLE);
    assign w_accept = w_idle & ce;

    // With zero wait states ACK is entered from IDLE, before the request is
    // latched, so the live inputs must drive the array on that edge.
    assign w_cur_we    = w_idle ? we     : r_we;
    assign w_cur_addr  = w_idle ? addr   : r_addr;
    assign w_cur_sel   = w_idle ? sel    : r_sel;
    assign w_cur_wdata = w_idle ? data_i : r_wdata;
    assign w_cur_err   = w_idle ? addr_out_of_range(addr, TOP_LSB) : r_err;
    assign w_word_idx  = ADDR_W'(w_cur_addr >> OFF_W);

    assign w_enter_ack = (w_next == DRAM_ACK) & (r_state != DRAM_ACK) & ~rst;
    assign w_rd_en     = w_enter_ack & ~w_cur_we & ~w_cur_err;
    assign w_wr_lane   = {BYTES{w_enter_ack & w_cur_we & ~w_cur_err}} & w_cur_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRAM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            DRAM_IDLE: begin
                if (ce) begin
                    w_next = (WAIT_CYCLES > 0) ? DRAM_WAIT : DRAM_ACK;
                end
            end
            DRAM_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = DRAM_ACK;
                end
            end
            DRAM_ACK: w_next = DRAM_IDLE;
            default:  w_next = DRAM_IDLE;
        endcase
    end

    always_comb begin
        ack_o   = (r_state == DRAM_ACK);
        err_o   = (r_state == DRAM_ACK) & r_err;
        stall_o = ce & (r_state != DRAM_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == DRAM_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_sel   <= sel;
            r_wdata <= data_i;
            r_err   <= addr_out_of_range(addr, TOP_LSB);
        end
    end

    for (genvar g = 0; g < BYTES; g++) begin : g_lane
        data_ram_ws_byte_lane #(
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_wr_en (w_wr_lane[g]),
            .i_rd_en (w_rd_en),
            .i_addr  (w_word_idx),
            .i_wdata (w_cur_wdata[8*g +: 8]),
            .o_rdata (data_o[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: three instances (WAIT_CYCLES 2, 3, 0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_data_ram_ws;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst     [N];
    logic        ce      [N];
    logic        we      [N];
    logic [31:0] addr    [N];
    logic [3:0]  sel     [N];
    logic [31:0] data_i  [N];
    logic [31:0] data_o  [N];
    logic        ack_o   [N];
    logic        err_o   [N];
    logic        stall_o [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_ram_ws #(
            .DATA_W      (32),
            .ADDR_W      (17),
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .ce      (ce[g]),
            .we      (we[g]),
            .addr    (addr[g]),
            .sel     (sel[g]),
            .data_i  (data_i[g]),
            .data_o  (data_o[g]),
            .ack_o   (ack_o[g]),
            .err_o   (err_o[g]),
            .stall_o (stall_o[g])
        );
    end

    int          checks   = 0;
    int          failures = 0;
    longint      cycle    = 0;
    bit          chk_en   = 1'b0;

    // Expected completion of the single outstanding access per instance.
    longint      exp_ack_cyc [N];
    logic [31:0] exp_data    [N];
    logic [31:0] exp_mask    [N];
    logic        exp_err     [N];

    // Model memory keyed by instance and word index, with per-byte "known" flags.
    logic [31:0] mdl_mem   [longint];
    logic [3:0]  mdl_known [longint];

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 3 : 0);
    endfunction

    function automatic longint key_of(input int d, input logic [31:0] a);
        return (longint'(d) << 32) | longint'((a >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h300 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
            a = a | (32'h1 << $urandom_range(19, 31));
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < N; d++) begin
                logic        ea;
                logic [31:0] em;
                logic [31:0] ed;
                ea = (cycle == exp_ack_cyc[d]);
                em = ea ? exp_mask[d] : 32'hFFFF_FFFF;
                ed = ea ? exp_data[d] : 32'h0;
                check($sformatf("dut%0d ack_o", d), 32'(ack_o[d]), 32'(ea));
                check($sformatf("dut%0d stall_o", d), 32'(stall_o[d]), 32'(ce[d] & ~ea));
                check($sformatf("dut%0d err_o", d), 32'(err_o[d]), 32'(ea & exp_err[d]));
                check($sformatf("dut%0d data_o", d), data_o[d] & em, ed & em);
            end
        end
    end

    // One complete access; returns the outputs sampled in the expected ack cycle.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] wd,
                          input bit churn, input bit drop, input bit hold,
                          output logic [31:0] got_data, output logic got_err,
                          output logic got_ack);
        longint      acc;
        longint      k;
        logic        e;
        logic [31:0] ed;
        logic [31:0] em;
        logic [31:0] tmp;
        logic [3:0]  kn;
        @(posedge clk); #1;
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; data_i[d] = wd;
        acc = cycle;
        k   = key_of(d, a);
        e   = (a >> 19) != 32'h0;
        ed  = 32'h0;
        em  = 32'hFFFF_FFFF;
        if (!e && !w) begin
            em = 32'h0;
            if (mdl_known.exists(k)) begin
                for (int i = 0; i < 4; i++) begin
                    if (mdl_known[k][i]) em[8*i +: 8] = 8'hFF;
                end
                ed = mdl_mem[k] & em;
            end
        end
        exp_err[d]     = e;
        exp_data[d]    = ed;
        exp_mask[d]    = em;
        exp_ack_cyc[d] = acc + 1 + wait_of(d);
        repeat (1 + wait_of(d)) begin
            @(posedge clk); #1;
            if (churn) begin
                we[d] = 1'($urandom); addr[d] = $urandom;
                sel[d] = 4'($urandom); data_i[d] = $urandom;
            end
            if (drop) ce[d] = 1'b0;
        end
        got_ack  = ack_o[d];
        got_data = data_o[d];
        got_err  = err_o[d];
        if (w && !e) begin
            tmp = mdl_known.exists(k) ? mdl_mem[k] : 32'h0;
            kn  = mdl_known.exists(k) ? mdl_known[k] : 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    tmp[8*i +: 8] = wd[8*i +: 8];
                    kn[i] = 1'b1;
                end
            end
            mdl_mem[k]   = tmp;
            mdl_known[k] = kn;
        end
        if (!hold) ce[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        logic [31:0] gd;
        logic        ge;
        logic        ga;
        longint      t0;

        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0;
            sel[d] = 4'h0; data_i[d] = 32'h0; exp_ack_cyc[d] = -1;
            exp_data[d] = 32'h0; exp_mask[d] = 32'h0; exp_err[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset dut%0d ack_o", d), 32'(ack_o[d]), 32'h0);
            check($sformatf("reset dut%0d err_o", d), 32'(err_o[d]), 32'h0);
            check($sformatf("reset dut%0d data_o", d), data_o[d], 32'h0);
            check($sformatf("reset dut%0d stall_o", d), 32'(stall_o[d]), 32'h0);
            rst[d] = 1'b0;
        end
        chk_en = 1'b1;

        // Full write then read, byte lanes and range error on the 2-wait instance.
        access(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("write 0x100 ack at T+3", 32'(ga), 32'h1);
        access(0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("read 0x100 data", gd, 32'hDEADBEEF);
        access(0, 1'b1, 32'h100, 4'b0101, 32'h11223344, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        access(0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("byte lane merge data", gd, 32'hDE22BE44);
        access(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        access(0, 1'b1, 32'h0008_0000, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("range write err_o", 32'(ge), 32'h1);
        access(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("read 0x0 after range write", gd, 32'hCAFEF00D);
        access(0, 1'b0, 32'h0008_0000, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("range read err_o", 32'(ge), 32'h1);
        check("range read data_o", gd, 32'h0);

        // Reset in the middle of a write on the 3-wait instance.
        access(1, 1'b1, 32'h200, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        @(posedge clk); #1;
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h200; sel[1] = 4'hF; data_i[1] = 32'h55;
        t0 = cycle;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset pulse lands in T+2", 32'(cycle - t0), 32'd2);
        rst[1] = 1'b1; ce[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        access(1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        check("read 0x200 after aborted write", gd, 32'h12345678);

        // Zero-wait back-to-back reads with ce held high.
        access(2, 1'b1, 32'h40, 4'hF, 32'hA5A50F0F, 1'b0, 1'b0, 1'b0, gd, ge, ga);
        for (int i = 0; i < 6; i++) begin
            access(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0, (i < 5), gd, ge, ga);
        end
        check("back-to-back read data", gd, 32'hA5A50F0F);

        // Randomised traffic with field churn, ce drops and held ce.
        for (int d = 0; d < N; d++) begin
            for (int n = 0; n < 60; n++) begin
                bit hold;
                hold = ($urandom_range(0, 3) == 0) && (n != 59);
                access(d, 1'(($urandom_range(0, 2) == 0)), rand_addr(), 4'($urandom),
                       $urandom, 1'($urandom), 1'($urandom), hold, gd, ge, ga);
                if (!hold) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
